// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM reader/writer arbiter and its adapters.
package sdram_arb_pkg;

    localparam int SDRAM_ADDR_W = 24;   // bank(2) + row(13) + column(9)
    localparam int SDRAM_DATA_W = 16;

    // Bit positions inside the base controller iCall/oDone vectors
    localparam int CALL_RD = 0;
    localparam int CALL_WR = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_RD = 2'd1,
        GRANT_WR = 2'd2,
        RELEASE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        SRV_RD = 1'b0,
        SRV_WR = 1'b1
    } served_e;

endpackage

// File: rtl/sdram_arb_timeout.sv
// Grant watchdog: cleared when an access is granted, counts while it is
// outstanding, and flags the terminal count TIMEOUT_CYCLES-1.
module sdram_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Per-access arbiter sharing the SDRAM base controller between the display
// reader and the draw writer. SDRAM_ARB_ROUND_ROBIN_EN selects round-robin
// tie breaking; otherwise the reader always wins ties.
module sdram_rw_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = SDRAM_ADDR_W,
    parameter int DATA_W         = SDRAM_DATA_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    output logic [1:0]        sd_call,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_wdata,
    input  logic [1:0]        sd_done,
    input  logic [DATA_W-1:0] sd_rdata,
    output logic              err
);

    arb_state_e state, state_nxt;
    logic       grant_rd, grant_wr;
    logic       pick_wr;
    logic       err_set;
    logic       tc;
    logic       in_grant;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    served_e last_served;

    // On a tie the requester that was not served last goes next
    assign pick_wr = wr_req && (!rd_req || (last_served == SRV_RD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_served <= SRV_WR;
        end else if (grant_rd) begin
            last_served <= SRV_RD;
        end else if (grant_wr) begin
            last_served <= SRV_WR;
        end
    end
`else
    // Display refresh must never underrun, so the reader wins every tie
    assign pick_wr = wr_req && !rd_req;
`endif

    assign in_grant = (state == GRANT_RD) || (state == GRANT_WR);

    sdram_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(grant_rd || grant_wr),
        .run  (in_grant),
        .tc   (tc)
    );

    always_comb begin
        state_nxt = state;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (en && (rd_req || wr_req)) begin
                    if (pick_wr) begin
                        grant_wr  = 1'b1;
                        state_nxt = GRANT_WR;
                    end else begin
                        grant_rd  = 1'b1;
                        state_nxt = GRANT_RD;
                    end
                end
            end
            GRANT_RD: begin
                if (sd_done[CALL_RD]) begin
                    rd_done   = rst_n;
                    state_nxt = RELEASE;
                end else if (tc) begin
                    err_set   = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            GRANT_WR: begin
                if (sd_done[CALL_WR]) begin
                    wr_done   = rst_n;
                    state_nxt = RELEASE;
                end else if (tc) begin
                    err_set   = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sd_call  <= 2'b00;
            sd_addr  <= '0;
            sd_wdata <= '0;
            err      <= 1'b0;
        end else begin
            state            <= state_nxt;
            // Decoded from the next state, so the two call bits are exclusive
            sd_call[CALL_RD] <= (state_nxt == GRANT_RD);
            sd_call[CALL_WR] <= (state_nxt == GRANT_WR);
            if (grant_rd) begin
                sd_addr <= rd_addr;
            end else if (grant_wr) begin
                sd_addr  <= wr_addr;
                sd_wdata <= wr_data;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign rd_data = sd_rdata;

endmodule
